sar_adc_ctrl: RTL and testbench

Digital successive-approximation controller that closes the loop around the team's sky130 analog op-amp/comparator. It drives a binary-weighted DAC code into the analog macro and samples the comparator decision coming back out of it. It converts one analog input to a WIDTH-bit code per start request. It sits in the digital half of the Tiny Tapeout tile, between the analog pins (via the comparator output) and the dedicated digital I/O.

---
 rtl/sar_adc_ctrl_if.sv | 35 +++
 rtl/sar_adc_ctrl.sv | 149 ++++++++++++++
 tb/tb_sar_adc_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sar_adc_ctrl_if.sv
// rtl/sar_adc_ctrl_if.sv - conversion handshake and analog-side signals of the SAR controller
//
// Purpose: groups the start/done handshake, the comparator input and the
// DAC/track-hold outputs of sar_adc_ctrl into one bundle.
// Signals:
//   start      conversion request (requester -> controller)
//   cmp        asynchronous comparator decision, 1 = Vin >= Vdac
//   sample_en  closes the track/hold switch
//   dac_code   WIDTH-bit code driven to the DAC
//   busy       conversion in progress
//   done       one-cycle pulse, result valid
//   result     last completed conversion
// Modports: master = requester/analog side, slave = controller.

interface sar_adc_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic             cmp;
  logic             sample_en;
  logic [WIDTH-1:0] dac_code;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, cmp,
    input  sample_en, dac_code, busy, done, result
  );

  modport slave (
    input  start, cmp,
    output sample_en, dac_code, busy, done, result
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - successive-approximation ADC controller around an external DAC/comparator
//
// Purpose: per accepted start, samples the input on the track/hold, then
// binary-searches a WIDTH-bit DAC code MSB first using the synchronized
// comparator decision, and publishes the final code on result with a done pulse.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  sar_adc_ctrl_if.slave: start, cmp in; sample_en, dac_code, busy,
//        done, result out

module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst,
  sar_adc_ctrl_if.slave bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    SETTLE = 3'd2,
    DECIDE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cmp_s1_q, cmp_s2_q;

  logic             sample_en_c;
  logic             busy_c;
  logic             done_c;
  logic [WIDTH-1:0] dac_code_c;
  logic [WIDTH-1:0] test_bit;
  logic [WIDTH-1:0] kept_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      code_q   <= '0;
      result_q <= '0;
      cmp_s1_q <= 1'b0;
      cmp_s2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      code_q   <= code_d;
      result_q <= result_d;
      // cmp is asynchronous to clk; only cmp_s2_q is ever consumed.
      cmp_s1_q <= bus.cmp;
      cmp_s2_q <= cmp_s1_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    code_d      = code_q;
    result_d    = result_q;
    sample_en_c = 1'b0;
    busy_c      = 1'b0;
    done_c      = 1'b0;
    dac_code_c  = '0;
    test_bit    = ONE << idx_q;
    // Trial code with the bit under test resolved by the comparator.
    kept_code   = cmp_s2_q ? code_q : (code_q & ~test_bit);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SAMPLE;
          cnt_d   = '0;
          idx_d   = IDX_W'(WIDTH - 1);
          code_d  = '0;
        end
      end

      SAMPLE: begin
        sample_en_c = 1'b1;
        busy_c      = 1'b1;
        if (cnt_q == 4'(SAMPLE_CYCLES - 1)) begin
          state_d = SETTLE;
          cnt_d   = '0;
          code_d  = ONE << (WIDTH - 1);
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      SETTLE: begin
        busy_c     = 1'b1;
        dac_code_c = code_q;
        if (cnt_q == 4'(SETTLE_CYCLES - 1)) begin
          state_d = DECIDE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      DECIDE: begin
        busy_c     = 1'b1;
        dac_code_c = code_q;
        if (idx_q != '0) begin
          code_d  = kept_code | (test_bit >> 1);
          idx_d   = idx_q - 1'b1;
          state_d = SETTLE;
        end else begin
          // Result is loaded here so it changes on the edge that raises done.
          code_d   = kept_code;
          result_d = kept_code;
          state_d  = DONE;
        end
      end

      DONE: begin
        busy_c     = 1'b1;
        done_c     = 1'b1;
        dac_code_c = code_q;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.sample_en = sample_en_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.dac_code  = dac_code_c;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - directed, table-driven bench for sar_adc_ctrl at default parameters

module tb_sar_adc_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sar_adc_ctrl_if #(.WIDTH(8)) bus ();

  sar_adc_ctrl #(
    .WIDTH(8),
    .SAMPLE_CYCLES(2),
    .SETTLE_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Comparator model: one cycle of delay from dac_code, optionally replaced
  // by an off-clock toggling noise source.
  logic [7:0] vin_code;
  logic       cmp_model;
  logic       cmp_force;
  logic       cmp_noise;

  always @(posedge clk) cmp_model <= (vin_code >= bus.dac_code);
  assign bus.cmp = cmp_force ? cmp_noise : cmp_model;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] vin;
    logic [7:0] exp_res;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] trials_5a[8];
  logic [7:0] last_res;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp_v);
    end
  endtask

  // Start a conversion in the current idle cycle (cycle 0) and watch cycles 1..40.
  task automatic run_conv(input logic [7:0] vin, input logic [7:0] exp_res,
                          input logic [7:0] prev_res, input bit check_trials,
                          input bit extra_start, input bit noisy, input string nm);
    int done_cnt;
    int done_cyc;
    vin_code = vin;
    @(negedge clk);
    chk({nm, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b1;
    done_cnt  = 0;
    done_cyc  = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = (extra_start && c == 10);
      if (c == 1) begin
        chk({nm, "_samp_en"}, {31'd0, bus.sample_en}, 32'd1);
        chk({nm, "_samp_busy"}, {31'd0, bus.busy}, 32'd1);
        chk({nm, "_samp_dac"}, {24'd0, bus.dac_code}, 32'd0);
      end
      if (check_trials && c >= 3 && c <= 34)
        chk($sformatf("%s_trial_c%0d", nm, c), {24'd0, bus.dac_code},
            {24'd0, trials_5a[(c - 3) / 4]});
      if (c == 20) chk({nm, "_res_held"}, {24'd0, bus.result}, {24'd0, prev_res});
      if (bus.done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == 35) begin
        chk({nm, "_result"}, {24'd0, bus.result}, {24'd0, exp_res});
        chk({nm, "_done_dac"}, {24'd0, bus.dac_code}, {24'd0, exp_res});
      end
      if (c == 36) chk({nm, "_busy_drop"}, {31'd0, bus.busy}, 32'd0);
      if (c == 38) chk({nm, "_no_restart"}, {31'd0, bus.sample_en}, 32'd0);
      if (noisy && c <= 2) begin
        cmp_force = 1'b1;
        #2 cmp_noise = ~cmp_noise;
        #1 cmp_noise = ~cmp_noise;
        #3 cmp_noise = ~cmp_noise;
      end
      if (noisy && c == 3) cmp_force = 1'b0;
    end
    chk({nm, "_done_cyc"}, done_cyc, 35);
    chk({nm, "_done_cnt"}, done_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int d1, d2, dcnt, low_cnt, low_cyc;

    vecs[0] = '{vin: 8'h5A, exp_res: 8'h5A};
    vecs[1] = '{vin: 8'h00, exp_res: 8'h00};
    vecs[2] = '{vin: 8'hFF, exp_res: 8'hFF};
    vecs[3] = '{vin: 8'h01, exp_res: 8'h01};
    vecs[4] = '{vin: 8'h80, exp_res: 8'h80};
    vecs[5] = '{vin: 8'h7F, exp_res: 8'h7F};
    vecs[6] = '{vin: 8'hA5, exp_res: 8'hA5};

    trials_5a[0] = 8'h80; trials_5a[1] = 8'h40; trials_5a[2] = 8'h60; trials_5a[3] = 8'h50;
    trials_5a[4] = 8'h58; trials_5a[5] = 8'h5C; trials_5a[6] = 8'h5A; trials_5a[7] = 8'h5B;

    rst       = 1'b1;
    bus.start = 1'b0;
    vin_code  = 8'h00;
    cmp_force = 1'b0;
    cmp_noise = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_sample_en", {31'd0, bus.sample_en}, 32'd0);
    chk("rst_dac", {24'd0, bus.dac_code}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_result", {24'd0, bus.result}, 32'd0);
    chk("rst_sync_x", {30'd0, $isunknown(dut.cmp_s1_q), $isunknown(dut.cmp_s2_q)}, 32'd0);
    rst = 1'b0;

    last_res = 8'h00;
    for (int i = 0; i < 7; i++) begin
      run_conv(vecs[i].vin, vecs[i].exp_res, last_res, (i == 0), 1'b0, 1'b0,
               $sformatf("vec%0d", i));
      last_res = vecs[i].exp_res;
    end

    run_conv(8'h96, 8'h96, last_res, 1'b0, 1'b1, 1'b0, "ignore_start");
    last_res = 8'h96;

    run_conv(8'hC3, 8'hC3, last_res, 1'b0, 1'b0, 1'b1, "noisy_cmp");
    last_res = 8'hC3;

    // start held high for 100 cycles: back-to-back conversions.
    vin_code = 8'h33;
    @(negedge clk);
    bus.start = 1'b1;
    d1 = -1; d2 = -1; dcnt = 0; low_cnt = 0; low_cyc = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.done) begin
        dcnt++;
        if (d1 < 0) d1 = c; else d2 = c;
        chk($sformatf("held_res_c%0d", c), {24'd0, bus.result}, 32'h33);
      end
      if (c <= 71 && !bus.busy) begin
        low_cnt++;
        low_cyc = c;
      end
    end
    bus.start = 1'b0;
    chk("held_done1", d1, 35);
    chk("held_done2", d2, 71);
    chk("held_done_cnt", dcnt, 2);
    chk("held_low_cnt", low_cnt, 1);
    chk("held_low_cyc", low_cyc, 36);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk("held_drain", {31'd0, bus.busy}, 32'd0);
    last_res = 8'h33;

    // Reset in the middle of a conversion.
    vin_code = 8'h5A;
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_sample_en", {31'd0, bus.sample_en}, 32'd0);
    chk("mid_rst_dac", {24'd0, bus.dac_code}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
    chk("mid_rst_result", {24'd0, bus.result}, 32'd0);
    chk("mid_rst_state", {29'd0, dut.state_q}, 32'd0);
    chk("mid_rst_sync", {30'd0, dut.cmp_s1_q, dut.cmp_s2_q}, 32'd0);
    rst = 1'b0;

    run_conv(8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
